// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: divides clock into sclk and emits sample/shift/done strobes.
// Latency: busy one cycle after an accepted start; toggle k at k*(div+1) enabled cycles after busy.
// Backpressure: enable low freezes counters and sclk while busy; start is ignored unless idle.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   enable                cycle qualifier while busy
//   div, cpol, cpha, nbits transfer configuration, captured when start is accepted
//   start                 request pulse, honoured only in IDLE
//   busy, sclk            transfer in progress, generated serial clock
//   sample, shift, done   one-cycle strobes
//
// Optional feature macro: SPI_SCLK_GEN_LEAD_DELAY_EN inserts a LEAD state of div+1
// enabled cycles between busy rising and the first half-period of sclk.
module spi_sclk_gen #(
   parameter int DIV_W = 16,
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable,
   input  logic [DIV_W-1:0] div,
   input  logic             cpol,
   input  logic             cpha,
   input  logic [CNT_W-1:0] nbits,
   input  logic             start,
   output logic             busy,
   output logic             sclk,
   output logic             sample,
   output logic             shift,
   output logic             done
);

`ifdef SPI_SCLK_GEN_LEAD_DELAY_EN
   typedef enum logic [1:0] {IDLE, RUN, TAIL, LEAD} state_t;
`else
   typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;
`endif

   localparam logic [DIV_W-1:0] DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W:0]   EDGE_ONE = {{CNT_W{1'b0}}, 1'b1};

   state_t           state, state_d;
   logic [DIV_W-1:0] cnt, cnt_d;
   // One bit wider than nbits so that 2*nbits fits at the maximum nbits.
   logic [CNT_W:0]   edge_cnt, edge_d;
   logic [DIV_W-1:0] div_q;
   logic             cpol_q, cpha_q;
   logic [CNT_W-1:0] nbits_q;
   logic             load;
   logic             sclk_d, busy_d, sample_d, shift_d, done_d;
   logic             wrap, leading, last_edge;

   assign wrap      = (cnt == div_q);
   // edge_cnt counts toggles already made, so an even count means the next one leads.
   assign leading   = ~edge_cnt[0];
   assign last_edge = (edge_cnt == ({nbits_q, 1'b0} - EDGE_ONE));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_d;
   end

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      edge_d   = edge_cnt;
      sclk_d   = sclk;
      busy_d   = busy;
      sample_d = 1'b0;
      shift_d  = 1'b0;
      done_d   = 1'b0;
      load     = 1'b0;
      case (state)
         IDLE: begin
            sclk_d = cpol;
            busy_d = 1'b0;
            if (start && enable) begin
               if (nbits != '0) begin
                  load   = 1'b1;
                  cnt_d  = '0;
                  edge_d = '0;
                  busy_d = 1'b1;
`ifdef SPI_SCLK_GEN_LEAD_DELAY_EN
                  state_d = LEAD;
`else
                  state_d = RUN;
`endif
               end else begin
                  done_d = 1'b1;
               end
            end
         end
`ifdef SPI_SCLK_GEN_LEAD_DELAY_EN
         LEAD: begin
            if (enable) begin
               if (wrap) begin
                  cnt_d   = '0;
                  state_d = RUN;
               end else begin
                  cnt_d = cnt + DIV_ONE;
               end
            end
         end
`endif
         RUN: begin
            if (enable) begin
               if (wrap) begin
                  cnt_d    = '0;
                  sclk_d   = ~sclk;
                  edge_d   = edge_cnt + EDGE_ONE;
                  // cpha=0 samples on the leading edge, cpha=1 on the trailing edge.
                  sample_d = leading ^ cpha_q;
                  shift_d  = ~(leading ^ cpha_q);
                  if (last_edge) state_d = TAIL;
               end else begin
                  cnt_d = cnt + DIV_ONE;
               end
            end
         end
         TAIL: begin
            if (enable) begin
               if (wrap) begin
                  cnt_d   = '0;
                  edge_d  = '0;
                  sclk_d  = cpol_q;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  cnt_d = cnt + DIV_ONE;
               end
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt      <= '0;
         edge_cnt <= '0;
         div_q    <= '0;
         cpol_q   <= 1'b0;
         cpha_q   <= 1'b0;
         nbits_q  <= '0;
         sclk     <= 1'b0;
         busy     <= 1'b0;
         sample   <= 1'b0;
         shift    <= 1'b0;
         done     <= 1'b0;
      end else begin
         cnt      <= cnt_d;
         edge_cnt <= edge_d;
         sclk     <= sclk_d;
         busy     <= busy_d;
         sample   <= sample_d;
         shift    <= shift_d;
         done     <= done_d;
         if (load) begin
            div_q   <= div;
            cpol_q  <= cpol;
            cpha_q  <= cpha;
            nbits_q <= nbits;
         end
      end
   end

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Self-checking bench for spi_sclk_gen against a cycle-count reference model.
module tb_spi_sclk_gen;

   logic        clock;
   logic        reset;
   logic        enable;
   logic [15:0] div;
   logic        cpol;
   logic        cpha;
   logic [5:0]  nbits;
   logic        start;
   logic        busy, sclk, sample, shift, done;

   int errors = 0;
   int checks = 0;

`ifdef SPI_SCLK_GEN_LEAD_DELAY_EN
   localparam bit LEAD_ON = 1'b1;
`else
   localparam bit LEAD_ON = 1'b0;
`endif

   spi_sclk_gen #(.DIV_W(16), .CNT_W(6)) dut (
      .clock (clock),
      .reset (reset),
      .enable(enable),
      .div   (div),
      .cpol  (cpol),
      .cpha  (cpha),
      .nbits (nbits),
      .start (start),
      .busy  (busy),
      .sclk  (sclk),
      .sample(sample),
      .shift (shift),
      .done  (done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // One transfer. Offsets count edges after the start cycle: busy at 1.
   // The model tracks enabled cycles e since busy rose; toggle k happens at
   // e = L + k*(div+1), done at e = L + (2n+1)*(div+1).
   task automatic run_xfer(input int dv, input bit cp, input bit ch, input int nb,
                           input int en_pct, input bit noise,
                           input int frz_at, input int frz_len,
                           output int first_t, output int done_t);
      int e, lead, k, tg, c, n_smp, n_shf;
      bit en_now, fin, x_sclk, x_smp, x_shf, x_done;
      logic [4:0] got, expv;
      lead = LEAD_ON ? dv + 1 : 0;
      first_t = -1; done_t = -1; n_smp = 0; n_shf = 0; e = 0; fin = 1'b0;
      @(negedge clock);
      div = 16'(dv); cpol = cp; cpha = ch; nbits = 6'(nb); start = 1'b1; enable = 1'b1;
      @(posedge clock);
      #1;
      got  = {busy, sclk, sample, shift, done};
      expv = (nb != 0) ? {1'b1, cp, 3'b000} : {1'b0, cp, 3'b001};
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL start_resp got=%b exp=%b", got, expv);
      end
      if (nb == 0) begin
         fin = 1'b1;
         done_t = 1;
      end
      c = 1;
      while (!fin && c < 4000) begin
         @(negedge clock);
         start  = 1'b0;
         en_now = ($urandom_range(99) < en_pct);
         if (frz_at > 0 && c >= frz_at && c < frz_at + frz_len) en_now = 1'b0;
         enable = en_now;
         if (noise) begin
            start = 1'($urandom);
            div   = 16'($urandom);
            cpol  = 1'($urandom);
            cpha  = 1'($urandom);
            nbits = 6'($urandom);
         end
         @(posedge clock);
         if (en_now) e++;
         tg = (e >= lead) ? (e - lead) / (dv + 1) : 0;
         if (tg > 2 * nb) tg = 2 * nb;
         x_sclk = cp ^ tg[0];
         k = (e > lead && ((e - lead) % (dv + 1)) == 0) ? (e - lead) / (dv + 1) : 0;
         x_smp  = en_now && k >= 1 && k <= 2 * nb && (((k % 2) == 1) == !ch);
         x_shf  = en_now && k >= 1 && k <= 2 * nb && (((k % 2) == 1) != !ch);
         x_done = en_now && (e == lead + (2 * nb + 1) * (dv + 1));
         #1;
         got  = {busy, sclk, sample, shift, done};
         expv = {!x_done, x_sclk, x_smp, x_shf, x_done};
         checks++;
         if (got !== expv) begin
            errors++;
            $display("FAIL xfer c=%0d got=%b exp=%b (busy,sclk,smp,shf,done)", c + 1, got, expv);
         end
         if (sample) n_smp++;
         if (shift)  n_shf++;
         if ((sample || shift) && first_t < 0) first_t = c + 1;
         if (done) done_t = c + 1;
         if (x_done || done) fin = 1'b1;
         c++;
      end
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL timeout got=busy exp=done within 4000 cycles");
      end
      checks++;
      if (n_smp !== nb) begin
         errors++;
         $display("FAIL sample_count got=%0d exp=%0d", n_smp, nb);
      end
      checks++;
      if (n_shf !== nb) begin
         errors++;
         $display("FAIL shift_count got=%0d exp=%0d", n_shf, nb);
      end
      @(negedge clock);
      start = 1'b0; enable = 1'b1; cpol = cp;
      @(posedge clock);
      #1;
      got  = {busy, sclk, sample, shift, done};
      expv = {1'b0, cp, 3'b000};
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL idle_after got=%b exp=%b", got, expv);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; start = 1'b0; div = 16'd1;
      cpol = 1'b1; cpha = 1'b0; nbits = 6'd8;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if ({busy, sclk, sample, shift, done} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_outputs got=%b exp=00000", {busy, sclk, sample, shift, done});
      end
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      checks++;
      if (sclk !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_release got=sclk%b busy%b exp=sclk1 busy0", sclk, busy);
      end
   endtask

   task automatic test_basic();
      int ft, dt, lead;
      lead = LEAD_ON ? 2 : 0;
      run_xfer(1, 1'b0, 1'b0, 8, 100, 1'b0, 0, 0, ft, dt);
      checks++;
      if (ft !== 3 + lead) begin
         errors++;
         $display("FAIL basic_first_edge got=%0d exp=%0d", ft, 3 + lead);
      end
      checks++;
      if (dt !== 35 + lead) begin
         errors++;
         $display("FAIL basic_done got=%0d exp=%0d", dt, 35 + lead);
      end
   endtask

   task automatic test_mode3();
      int ft, dt;
      run_xfer(0, 1'b1, 1'b1, 4, 100, 1'b0, 0, 0, ft, dt);
      checks++;
      if (dt !== (LEAD_ON ? 11 : 10)) begin
         errors++;
         $display("FAIL mode3_done got=%0d exp=%0d", dt, LEAD_ON ? 11 : 10);
      end
   endtask

   task automatic test_freeze();
      int ft, dt, nominal;
      nominal = (LEAD_ON ? 4 : 0) + 17 * 4 + 1;
      run_xfer(3, 1'b0, 1'b1, 8, 100, 1'b0, 10, 5, ft, dt);
      checks++;
      if (dt !== nominal + 5) begin
         errors++;
         $display("FAIL freeze_done got=%0d exp=%0d", dt, nominal + 5);
      end
   endtask

   task automatic test_zero_and_ignored();
      int ft, dt;
      run_xfer(2, 1'b0, 1'b0, 0, 100, 1'b0, 0, 0, ft, dt);
      run_xfer(1, 1'b1, 1'b0, 8, 100, 1'b1, 0, 0, ft, dt);
   endtask

   task automatic test_reset_mid();
      int ft, dt, tg, c;
      bit prev;
      @(negedge clock);
      div = 16'd1; cpol = 1'b0; cpha = 1'b0; nbits = 6'd8; start = 1'b1; enable = 1'b1;
      @(posedge clock);
      #1;
      prev = sclk; tg = 0; c = 0;
      @(negedge clock);
      start = 1'b0;
      while (tg < 5 && c < 200) begin
         @(posedge clock);
         #1;
         if (sclk !== prev) tg++;
         prev = sclk;
         c++;
      end
      checks++;
      if (tg !== 5) begin
         errors++;
         $display("FAIL reset_mid_reach got=%0d exp=5 toggles", tg);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({busy, sclk, sample, shift, done} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_mid_async got=%b exp=00000", {busy, sclk, sample, shift, done});
      end
      repeat (3) begin
         @(posedge clock);
         #1;
         checks++;
         if ({busy, sclk, sample, shift, done} !== 5'b00000) begin
            errors++;
            $display("FAIL reset_mid_hold got=%b exp=00000", {busy, sclk, sample, shift, done});
         end
      end
      @(negedge clock);
      reset = 1'b0;
      @(posedge clock);
      #1;
      checks++;
      if ({busy, sclk, done} !== 3'b000) begin
         errors++;
         $display("FAIL reset_mid_release got=%b exp=000", {busy, sclk, done});
      end
      run_xfer(1, 1'b0, 1'b0, 8, 100, 1'b0, 0, 0, ft, dt);
   endtask

   task automatic test_random();
      int ft, dt;
      for (int i = 0; i < 8; i++) begin
         run_xfer($urandom_range(3), 1'($urandom), 1'($urandom), $urandom_range(5),
                  70, 1'b1, 0, 0, ft, dt);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_mode3();
      test_freeze();
      test_zero_and_ignored();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/spi_sclk_gen.md
SPI_SCLK_GEN -- requirements
Module: spi_sclk_gen

Interface
REQ-001 Parameter DIV_W, default 16: width of the half-period divider value.
REQ-002 Parameter CNT_W, default 6: width of the bits-per-transfer value.
REQ-003 clock  in  1  single clock; all state advances on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  cycle qualifier; low freezes all counters and outputs while busy.
REQ-006 div  in  DIV_W  half-period length minus one, in clock cycles.
REQ-007 cpol  in  1  idle level of sclk.
REQ-008 cpha  in  1  0: sample on leading edge, shift on trailing; 1: shift on leading, sample on trailing.
REQ-009 nbits  in  CNT_W  bits per transfer.
REQ-010 start  in  1  request pulse; accepted only in IDLE.
REQ-011 busy  out  1  transfer in progress.
REQ-012 sclk  out  1  generated serial clock.
REQ-013 sample  out  1  one-cycle strobe coincident with each sample edge.
REQ-014 shift  out  1  one-cycle strobe coincident with each shift edge.
REQ-015 done  out  1  one-cycle end-of-transfer pulse.

Function
REQ-016 States SHALL be IDLE, RUN and TAIL, plus LEAD when the configuration macro is defined.
REQ-017 In IDLE, sclk SHALL follow cpol one cycle later, and busy, sample, shift and done SHALL be 0.
REQ-018 A start with enable=1 and nbits!=0 in IDLE SHALL latch div, cpol, cpha and nbits, clear the half-period counter, and set busy on the next cycle.
REQ-019 start with nbits==0 SHALL produce a done pulse on the next cycle, with no busy and no sclk edge.
REQ-020 start while busy SHALL be ignored; input changes while busy SHALL have no effect, since latched values are used.
REQ-021 In RUN, the counter SHALL increment on each enabled cycle; when it equals the latched div, it SHALL wrap to 0 and sclk SHALL toggle.
REQ-022 The k-th toggle SHALL be visible k*(div+1) cycles after busy rises; div=0 gives sclk at clock/2.
REQ-023 Odd-numbered toggles SHALL be leading edges and even-numbered toggles trailing edges; exactly 2*nbits toggles SHALL occur per transfer.
REQ-024 sample and shift SHALL assert in the same cycle as their sclk toggle, selected per REQ-008; each SHALL assert exactly nbits times per transfer.
REQ-025 After the final toggle, the block SHALL enter TAIL, wait div+1 enabled cycles, then pulse done, drop busy in that same cycle, and return to IDLE.
REQ-026 sample and shift SHALL never both assert in one cycle, and neither SHALL assert outside RUN.
REQ-027 The edge counter SHALL be CNT_W+1 bits wide so that 2*nbits does not overflow at nbits = 2^CNT_W-1.

Reset
REQ-028 On reset, all outputs SHALL be 0, including sclk regardless of cpol, and the state SHALL be IDLE with counters cleared.
REQ-029 Reset mid-transfer SHALL abort immediately with no done pulse.
REQ-030 After reset release, sclk SHALL reach the cpol level one cycle later.

Configuration
REQ-031 Macro SPI_SCLK_GEN_LEAD_DELAY_EN.
- Defined: the LEAD state inserts div+1 enabled cycles after busy rises, before RUN, and all toggle times in REQ-022 shift by div+1.
- Undefined: there is no LEAD state, and RUN begins when busy rises.

Verification
REQ-032 div=1, nbits=8, cpol=0, cpha=0, start at T -> busy over T+1..T+34; rising edges at T+3, T+7, ... each with sample; falling edges with shift; done at T+35.
REQ-033 cpol=1, cpha=1, div=0, nbits=4 -> sclk idle high, 8 toggles on consecutive cycles, shift on falling edges, sample on rising edges, 4 of each strobe.
REQ-034 enable held low for 5 cycles mid-RUN (div=3) -> sclk, counters and strobes frozen; the transfer completes exactly 5 cycles later than nominal.
REQ-035 nbits=0 start -> done pulse next cycle, busy stays 0, sclk static; a start while busy (nbits=8) is ignored.
REQ-036 reset asserted at the 5th toggle -> all outputs 0 asynchronously, no done pulse; a new start after release runs normally.
REQ-037 With SPI_SCLK_GEN_LEAD_DELAY_EN defined, div=1, nbits=2 -> first toggle at T+5, done at T+13.
